// File: rtl/phase_diff_array.sv
// Multi-channel phase difference calculator: measures the gap between each nin[i]
// rising edge and the shared nref rising edge, and steps each lane's phase by that gap.

module phase_diff_lane #(
    parameter int PHASE_W   = 4,
    parameter int CNT_W     = 8,
    parameter int MAX_GAP   = 15,
    parameter int WRAP_MODE = 1
) (
    input  logic               sclk,
    input  logic               re,
    input  logic               ld,
    input  logic               er,
    input  logic               nin,
    input  logic [PHASE_W-1:0] phi_out,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_vld,
    output logic               lead,
    output logic               timeout
);
    typedef enum logic [1:0] {IDLE, CNT_IN, CNT_REF} state_t;

    localparam int EXT_W = PHASE_W + CNT_W + 1;
    localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(MAX_GAP);
    localparam logic signed [EXT_W-1:0] PH_MAX  = EXT_W'((1 << PHASE_W) - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               vld_q, vld_d;
    logic               lead_q, lead_d;
    logic               tout_q, tout_d;
    logic               nin_q, nin_qq;
    logic               ein;

    logic signed [EXT_W-1:0] phi_ext, cnt_ext, diff, sum;

    // Signed extension leaves room for the full negative range of phi - cnt
    function automatic logic [PHASE_W-1:0] fold(input logic signed [EXT_W-1:0] v);
        if (WRAP_MODE != 0)
            return v[PHASE_W-1:0];
        else if (v[EXT_W-1])
            return '0;
        else if (v > PH_MAX)
            return '1;
        else
            return v[PHASE_W-1:0];
    endfunction

    assign ein     = nin_q & ~nin_qq;
    assign phi_ext = signed'({{(EXT_W-PHASE_W){1'b0}}, phi_out});
    assign cnt_ext = signed'({{(EXT_W-CNT_W){1'b0}}, cnt_q});
    assign diff    = phi_ext - cnt_ext;
    assign sum     = phi_ext + cnt_ext;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        vld_d   = 1'b0;
        lead_d  = lead_q;
        tout_d  = 1'b0;
        if (ld) begin
            state_d = IDLE;
            cnt_d   = '0;
            phase_d = phi_out;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (ein && er) begin
                        phase_d = phi_out;
                        lead_d  = 1'b0;
                        vld_d   = 1'b1;
                    end else if (ein) begin
                        state_d = CNT_IN;
                        cnt_d   = CNT_W'(1);
                    end else if (er) begin
                        state_d = CNT_REF;
                        cnt_d   = CNT_W'(1);
                    end
                end
                CNT_IN: begin
                    if (er) begin
                        phase_d = fold(diff);
                        lead_d  = 1'b1;
                        vld_d   = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (ein) begin
                        cnt_d = CNT_W'(1);
                    end else if (cnt_q == CNT_MAX) begin
                        tout_d  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CNT_REF: begin
                    if (ein) begin
                        phase_d = fold(sum);
                        lead_d  = 1'b0;
                        vld_d   = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (er) begin
                        cnt_d = CNT_W'(1);
                    end else if (cnt_q == CNT_MAX) begin
                        tout_d  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sclk or posedge re) begin
        if (re) begin
            nin_q   <= 1'b0;
            nin_qq  <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            vld_q   <= 1'b0;
            lead_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            nin_q   <= nin;
            nin_qq  <= nin_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            vld_q   <= vld_d;
            lead_q  <= lead_d;
            tout_q  <= tout_d;
        end
    end

    assign phase     = phase_q;
    assign phase_vld = vld_q;
    assign lead      = lead_q;
    assign timeout   = tout_q;
endmodule

module phase_diff_array #(
    parameter int N_CH      = 5,
    parameter int PHASE_W   = 4,
    parameter int CNT_W     = 8,
    parameter int MAX_GAP   = 15,
    parameter int WRAP_MODE = 1
) (
    input  logic                    sclk,
    input  logic                    re,
    input  logic                    ld,
    input  logic                    nref,
    input  logic [N_CH-1:0]         nin,
    input  logic [PHASE_W-1:0]      phi_out,
    output logic [N_CH*PHASE_W-1:0] phase,
    output logic [N_CH-1:0]         phase_vld,
    output logic [N_CH-1:0]         lead,
    output logic [N_CH-1:0]         timeout
);
    logic nref_q, nref_qq;
    logic er;
    logic [N_CH-1:0][PHASE_W-1:0] phase_lanes;

    // One reference edge detector shared by every lane
    always_ff @(posedge sclk or posedge re) begin
        if (re) begin
            nref_q  <= 1'b0;
            nref_qq <= 1'b0;
        end else begin
            nref_q  <= nref;
            nref_qq <= nref_q;
        end
    end

    assign er = nref_q & ~nref_qq;

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        phase_diff_lane #(
            .PHASE_W  (PHASE_W),
            .CNT_W    (CNT_W),
            .MAX_GAP  (MAX_GAP),
            .WRAP_MODE(WRAP_MODE)
        ) u_lane (
            .sclk     (sclk),
            .re       (re),
            .ld       (ld),
            .er       (er),
            .nin      (nin[i]),
            .phi_out  (phi_out),
            .phase    (phase_lanes[i]),
            .phase_vld(phase_vld[i]),
            .lead     (lead[i]),
            .timeout  (timeout[i])
        );
    end

    assign phase = phase_lanes;
endmodule

// File: tb/tb_phase_diff_array.sv
// Directed bench for phase_diff_array: a wrapping and a saturating instance share stimulus.

module tb_phase_diff_array;
    logic        sclk = 1'b0;
    logic        re = 1'b1;
    logic        ld = 1'b0;
    logic        nref = 1'b0;
    logic [4:0]  nin = '0;
    logic [3:0]  phi_out = '0;
    logic [19:0] phase, phase_s;
    logic [4:0]  vld, vld_s, lead, lead_s, tout, tout_s;

    int n_chk = 0;
    int n_err = 0;

    always #5 sclk = ~sclk;

    phase_diff_array #(.N_CH(5), .PHASE_W(4), .CNT_W(8), .MAX_GAP(15), .WRAP_MODE(1)) dut (
        .sclk(sclk), .re(re), .ld(ld), .nref(nref), .nin(nin), .phi_out(phi_out),
        .phase(phase), .phase_vld(vld), .lead(lead), .timeout(tout)
    );

    phase_diff_array #(.N_CH(5), .PHASE_W(4), .CNT_W(8), .MAX_GAP(15), .WRAP_MODE(0)) dut_sat (
        .sclk(sclk), .re(re), .ld(ld), .nref(nref), .nin(nin), .phi_out(phi_out),
        .phase(phase_s), .phase_vld(vld_s), .lead(lead_s), .timeout(tout_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic clear(input logic [3:0] p);
        nin  = '0;
        nref = 1'b0;
        step(3);
        phi_out = p;
        ld = 1'b1;
        step(1);
        ld = 1'b0;
    endtask

    initial begin
        logic [4:0] acc;

        // reset state
        step(2);
        check("rst_phase", phase, 20'h0);
        check("rst_vld", vld, 5'h0);
        check("rst_lead", lead, 5'h0);
        check("rst_tout", tout, 5'h0);
        re = 1'b0;
        step(1);
        clear(4'd8);
        check("ld_init", phase, 20'h88888);

        // async reset in the middle of a CNT_IN measurement
        nin[0] = 1'b1;
        step(4);
        #2;
        re = 1'b1;
        #1;
        check("async_phase", phase, 20'h0);
        check("async_vld", vld, 5'h0);
        check("async_tout", tout, 5'h0);
        nin = '0;
        step(2);
        re = 1'b0;
        acc = '0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            acc = acc | vld | tout;
        end
        check("async_quiet", acc, 5'h0);
        check("async_hold", phase, 20'h0);

        // input leads by 3
        clear(4'd8);
        nin[0] = 1'b1;
        step(3);
        nref = 1'b1;
        step(1);
        check("in_lead_early", vld, 5'h0);
        step(1);
        check("in_lead_phase", phase, 20'h88885);
        check("in_lead_vld", vld, 5'b00001);
        check("in_lead_lead", lead[0], 1'b1);
        step(1);
        check("in_lead_pulse", vld, 5'h0);
        check("in_lead_hold", phase, 20'h88885);

        // reference leads by 4, two lanes close together
        clear(4'd8);
        nref = 1'b1;
        step(4);
        nin[2] = 1'b1;
        nin[3] = 1'b1;
        step(2);
        check("ref_lead_phase", phase, 20'h8CC88);
        check("ref_lead_vld", vld, 5'b01100);
        check("ref_lead_lead", lead[3:2], 2'b00);

        // simultaneous edges
        clear(4'd3);
        phi_out = 4'd8;
        nin[1] = 1'b1;
        nref = 1'b1;
        step(2);
        check("simul_phase", phase, 20'h33383);
        check("simul_vld", vld, 5'b00010);
        check("simul_lead", lead[1], 1'b0);

        // restart: second nin edge rearms the count
        clear(4'd8);
        nin[1] = 1'b1;
        step(3);
        nin[1] = 1'b0;
        step(3);
        nin[1] = 1'b1;
        step(2);
        nref = 1'b1;
        step(2);
        check("restart_phase", phase, 20'h88868);
        check("restart_vld", vld, 5'b00010);
        check("restart_lead", lead[1], 1'b1);

        // reference leads by 5 from 14: wrap vs saturate
        clear(4'd14);
        nref = 1'b1;
        step(5);
        nin[0] = 1'b1;
        step(2);
        check("wrap_hi", phase, 20'hEEEE3);
        check("sat_hi", phase_s, 20'hEEEEF);
        check("sat_hi_vld", vld_s, 5'b00001);

        // input leads by 5 from 2: wrap vs saturate
        clear(4'd2);
        nin[0] = 1'b1;
        step(5);
        nref = 1'b1;
        step(2);
        check("wrap_lo", phase, 20'h2222D);
        check("sat_lo", phase_s, 20'h22220);

        // timeout on lane 4
        clear(4'd8);
        nin[4] = 1'b1;
        acc = '0;
        for (int k = 0; k < 16; k++) begin
            step(1);
            acc = acc | tout | vld;
        end
        check("tout_early", acc, 5'h0);
        step(1);
        check("tout_pulse", tout, 5'b10000);
        check("tout_novld", vld, 5'h0);
        step(1);
        check("tout_once", tout, 5'h0);
        check("tout_phase", phase, 20'h88888);

        // load
        phi_out = 4'd9;
        ld = 1'b1;
        step(1);
        ld = 1'b0;
        check("ld_phase", phase, 20'h99999);
        check("ld_sat_phase", phase_s, 20'h99999);
        check("ld_vld", vld, 5'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
